// File: rtl/mux_arbiter_rr_pkg.sv
// Shared definitions for the round-robin 2:1 mux arbiter: FSM state
// encodings, selector values and parameter defaults.
package mux_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic SEL_PORT0 = 1'b0;
  localparam logic SEL_PORT1 = 1'b1;

  localparam int DEFAULT_DATA_W    = 2;
  localparam int DEFAULT_MAX_BURST = 4;
  localparam int DEFAULT_CNT_W     = 3;

endpackage

// File: rtl/mux_out_stage.sv
// Single-entry output register with valid/ready backpressure.
// A new word may be loaded whenever the stage is empty or is being drained
// in the same cycle, so a continuous stream runs at one word per clock.
module mux_out_stage #(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready_out,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              can_load
);

  // Room for a new word when empty or when the held word leaves this cycle.
  assign can_load = !valid_out || ready_out;

  // Output register: load wins; otherwise a consumed word clears valid and
  // the data value is left as it was.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
    end else if (load) begin
      data_out  <= load_data;
      valid_out <= 1'b1;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_arbiter_rr.sv
// Round-robin arbiter and sequencer for a shared 2:1 datapath mux.
// Two valid/ready producers compete for the mux; the owner streams words
// into a single-entry output stage, and a burst limit hands ownership to
// a waiting competitor after MAX_BURST consecutive transfers.
module mux_arbiter_rr
  import mux_arbiter_rr_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int MAX_BURST = DEFAULT_MAX_BURST,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid0,
  input  logic [DATA_W-1:0] data_in0,
  output logic              ready0,
  input  logic              valid1,
  input  logic [DATA_W-1:0] data_in1,
  output logic              ready1,
  output logic              selector,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_out
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [CNT_W:0]   MAX_EXT = (CNT_W+1)'(MAX_BURST);

  state_t            state_reg, state_next;
  logic              last_reg, last_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;

  logic              can_load;
  logic              load;
  logic [DATA_W-1:0] load_data;
  logic [CNT_W:0]    cnt_inc;
  logic              burst_done;
  logic              own_port;
  logic              own_valid;
  logic              other_valid;
  state_t            other_state;

  // Ownership decode: selector and readies come straight from the state
  // register, so there is no path from any valid input to a ready output.
  assign selector  = (state_reg == ST_OWN1) ? SEL_PORT1 : SEL_PORT0;
  assign ready0    = (state_reg == ST_OWN0) && can_load;
  assign ready1    = (state_reg == ST_OWN1) && can_load;
  assign load      = (valid0 && ready0) || (valid1 && ready1);
  assign load_data = (selector == SEL_PORT1) ? data_in1 : data_in0;

  // Burst bookkeeping in one extra bit so a saturated count cannot wrap.
  // ">=" also covers a competitor arriving after the count has saturated.
  assign cnt_inc    = {1'b0, cnt_reg} + 1'b1;
  assign burst_done = (cnt_inc >= MAX_EXT);

  assign own_port    = (state_reg == ST_OWN1);
  assign own_valid   = own_port ? valid1 : valid0;
  assign other_valid = own_port ? valid0 : valid1;
  assign other_state = own_port ? ST_OWN0 : ST_OWN1;

  // State, last-owner and burst-count registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic: IDLE arbitrates, an owner keeps the grant until it
  // drops valid or exhausts its burst while the other port is waiting.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (valid0 && valid1) begin
          state_next = last_reg ? ST_OWN0 : ST_OWN1;
        end else if (valid0) begin
          state_next = ST_OWN0;
        end else if (valid1) begin
          state_next = ST_OWN1;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (!own_valid) begin
          state_next = other_valid ? other_state : ST_IDLE;
          cnt_next   = '0;
          last_next  = own_port;
        end else if (load) begin
          if (burst_done && other_valid) begin
            state_next = other_state;
            cnt_next   = '0;
            last_next  = own_port;
          end else begin
            cnt_next = burst_done ? MAX_CNT : cnt_inc[CNT_W-1:0];
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  mux_out_stage #(
    .DATA_W (DATA_W)
  ) u_out_stage (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .can_load  (can_load)
  );

endmodule

// File: tb/tb_mux_arbiter_rr.sv
// Directed bench for mux_arbiter_rr: a table of per-cycle vectors for reset,
// round-robin bursts, backpressure and release, followed by hand-written
// sequences for burst-count saturation and asynchronous reset mid-burst.
module tb_mux_arbiter_rr;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic       clk;
  logic       reset;
  logic       valid0, valid1;
  logic [1:0] data_in0, data_in1;
  logic       ready0, ready1;
  logic       selector;
  logic [1:0] data_out;
  logic       valid_out;
  logic       ready_out;

  int nchecks;
  int nerrors;

  typedef struct {
    logic       rst;
    logic       v0;
    logic [1:0] d0;
    logic       v1;
    logic [1:0] d1;
    logic       ro;
    logic       r0;
    logic       r1;
    logic       sel;
    logic       vo;
    logic [1:0] dout;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl[$];

  mux_arbiter_rr #(
    .DATA_W    (2),
    .MAX_BURST (4),
    .CNT_W     (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid0    (valid0),
    .data_in0  (data_in0),
    .ready0    (ready0),
    .valid1    (valid1),
    .data_in1  (data_in1),
    .ready1    (ready1),
    .selector  (selector),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_out (ready_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerrors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic v0, input logic [1:0] d0,
                     input logic v1, input logic [1:0] d1, input logic ro,
                     input logic r0, input logic r1, input logic sel,
                     input logic vo, input logic [1:0] dout, input logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1; v.ro = ro;
    v.r0 = r0; v.r1 = r1; v.sel = sel; v.vo = vo; v.dout = dout; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  initial begin
    nchecks   = 0;
    nerrors   = 0;
    reset     = 1'b1;
    valid0    = 1'b1;
    valid1    = 1'b1;
    data_in0  = 2'd1;
    data_in1  = 2'd2;
    ready_out = 1'b1;

    // Each row: inputs driven at the falling edge; expected outputs are the
    // combinational readies/selector for those inputs and the registered
    // values left by the previous rising edge.
    //   rst v0 d0    v1 d1    ro   r0 r1 sel vo dout  cnt
    add(H, H, 2'd1, H, 2'd2, H,  L, L, L, L, 2'd0, 3'd0); // in reset
    add(L, H, 2'd1, H, 2'd2, H,  L, L, L, L, 2'd0, 3'd0); // IDLE, tie -> port 0
    add(L, H, 2'd1, H, 2'd2, H,  H, L, L, L, 2'd0, 3'd0); // OWN0 first word
    add(L, H, 2'd3, H, 2'd2, H,  H, L, L, H, 2'd1, 3'd1);
    add(L, H, 2'd0, H, 2'd2, H,  H, L, L, H, 2'd3, 3'd2);
    add(L, H, 2'd1, H, 2'd2, H,  H, L, L, H, 2'd0, 3'd3); // 4th word, handover
    add(L, H, 2'd2, H, 2'd2, H,  L, H, H, H, 2'd1, 3'd0); // OWN1, no bubble
    add(L, H, 2'd2, H, 2'd3, H,  L, H, H, H, 2'd2, 3'd1);
    add(L, H, 2'd2, H, 2'd0, H,  L, H, H, H, 2'd3, 3'd2);
    add(L, H, 2'd2, H, 2'd1, H,  L, H, H, H, 2'd0, 3'd3); // 4th word, handover
    add(L, H, 2'd2, H, 2'd1, L,  L, L, L, H, 2'd1, 3'd0); // backpressure 1
    add(L, H, 2'd2, H, 2'd1, L,  L, L, L, H, 2'd1, 3'd0); // backpressure 2
    add(L, H, 2'd2, H, 2'd1, L,  L, L, L, H, 2'd1, 3'd0); // backpressure 3
    add(L, H, 2'd2, H, 2'd1, H,  H, L, L, H, 2'd1, 3'd0); // release, loads now
    add(L, L, 2'd2, H, 2'd3, H,  H, L, L, H, 2'd2, 3'd1); // owner drops valid0
    add(L, L, 2'd2, H, 2'd3, H,  L, H, H, L, 2'd2, 3'd0); // OWN1, drained
    add(L, L, 2'd2, L, 2'd3, H,  L, H, H, H, 2'd3, 3'd1); // nobody valid
    add(L, L, 2'd2, L, 2'd3, H,  L, L, L, L, 2'd3, 3'd0); // IDLE, drained
    add(L, L, 2'd2, L, 2'd3, H,  L, L, L, L, 2'd3, 3'd0);

    foreach (tbl[k]) begin
      @(negedge clk);
      reset     = tbl[k].rst;
      valid0    = tbl[k].v0;
      data_in0  = tbl[k].d0;
      valid1    = tbl[k].v1;
      data_in1  = tbl[k].d1;
      ready_out = tbl[k].ro;
      #1;
      $display("row %0d: r0=%0b r1=%0b sel=%0b vo=%0b dout=%0d cnt=%0d",
               k, ready0, ready1, selector, valid_out, data_out, dut.cnt_reg);
      chk($sformatf("row%0d ready0", k),    int'(ready0),      int'(tbl[k].r0));
      chk($sformatf("row%0d ready1", k),    int'(ready1),      int'(tbl[k].r1));
      chk($sformatf("row%0d selector", k),  int'(selector),    int'(tbl[k].sel));
      chk($sformatf("row%0d valid_out", k), int'(valid_out),   int'(tbl[k].vo));
      chk($sformatf("row%0d data_out", k),  int'(data_out),    int'(tbl[k].dout));
      chk($sformatf("row%0d cnt", k),       int'(dut.cnt_reg), int'(tbl[k].cnt));
    end

    // Only port 1 requests: ten words stream out with no handover and the
    // burst count saturates at MAX_BURST.
    @(negedge clk);
    valid0   = 1'b0;
    valid1   = 1'b1;
    data_in1 = 2'd1;
    #1;
    chk("sat idle ready1", int'(ready1), 0);
    for (int i = 0; i < 10; i++) begin
      logic [1:0] w;
      logic [1:0] prev;
      w = i[1:0];
      prev = 2'(i - 1);
      @(negedge clk);
      data_in1 = w;
      #1;
      $display("sat word %0d: r1=%0b sel=%0b vo=%0b dout=%0d cnt=%0d",
               i, ready1, selector, valid_out, data_out, dut.cnt_reg);
      chk($sformatf("sat%0d ready1", i),   int'(ready1),      1);
      chk($sformatf("sat%0d ready0", i),   int'(ready0),      0);
      chk($sformatf("sat%0d selector", i), int'(selector),    1);
      chk($sformatf("sat%0d cnt", i),      int'(dut.cnt_reg), (i < 4) ? i : 4);
      chk($sformatf("sat%0d valid_out", i), int'(valid_out),  (i > 0) ? 1 : 0);
      if (i > 0) chk($sformatf("sat%0d data_out", i), int'(data_out), int'(prev));
    end

    // Port 0 arrives while the count is saturated: the next transfer from
    // port 1 is its last before the grant moves.
    @(negedge clk);
    valid0   = 1'b1;
    data_in0 = 2'd2;
    data_in1 = 2'd2;
    #1;
    $display("late competitor: r1=%0b cnt=%0d dout=%0d", ready1, dut.cnt_reg, data_out);
    chk("late ready1", int'(ready1),      1);
    chk("late cnt",    int'(dut.cnt_reg), 4);
    chk("late dout",   int'(data_out),    1);

    @(negedge clk);
    valid1   = 1'b0;
    data_in0 = 2'd1;
    #1;
    $display("handover: r0=%0b r1=%0b sel=%0b dout=%0d", ready0, ready1, selector, data_out);
    chk("handover selector", int'(selector),    0);
    chk("handover ready0",   int'(ready0),      1);
    chk("handover ready1",   int'(ready1),      0);
    chk("handover dout",     int'(data_out),    2);
    chk("handover cnt",      int'(dut.cnt_reg), 0);

    // Two words from port 0, then reset asserted between clock edges.
    @(negedge clk);
    data_in0 = 2'd3;
    #1;
    chk("burst cnt1", int'(dut.cnt_reg), 1);
    chk("burst dout1", int'(data_out),   1);
    @(negedge clk);
    #1;
    $display("mid-burst: cnt=%0d vo=%0b dout=%0d", dut.cnt_reg, valid_out, data_out);
    chk("midburst cnt",  int'(dut.cnt_reg), 2);
    chk("midburst vo",   int'(valid_out),   1);
    chk("midburst dout", int'(data_out),    3);
    #2;
    reset = 1'b1;
    #1;
    $display("async reset: vo=%0b dout=%0d r0=%0b sel=%0b", valid_out, data_out, ready0, selector);
    chk("areset vo",     int'(valid_out),   0);
    chk("areset dout",   int'(data_out),    0);
    chk("areset ready0", int'(ready0),      0);
    chk("areset cnt",    int'(dut.cnt_reg), 0);

    @(negedge clk);
    reset  = 1'b0;
    valid0 = 1'b1;
    valid1 = 1'b1;
    #1;
    $display("after reset: r0=%0b r1=%0b last=%0b", ready0, ready1, dut.last_reg);
    chk("post idle ready0", int'(ready0),       0);
    chk("post idle ready1", int'(ready1),       0);
    chk("post last",        int'(dut.last_reg), 1);
    @(negedge clk);
    #1;
    $display("first tie: r0=%0b r1=%0b sel=%0b", ready0, ready1, selector);
    chk("tie ready0",   int'(ready0),   1);
    chk("tie ready1",   int'(ready1),   0);
    chk("tie selector", int'(selector), 0);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule
